// File: rtl/router_pkt_reg_if.sv
// -----------------------------------------------------------------------------
// router_pkt_reg_if
// Bundles the byte-level signals of the router packet register: the source
// byte stream, the output-FIFO full flag, the router FSM strobes, and every
// status/data output of the block.
//   master : the side that drives packet data and FSM strobes (FSM / bench)
//   slave  : the packet register itself
// Parameters must match those of the connected router_pkt_reg instance.
// -----------------------------------------------------------------------------
interface router_pkt_reg_if #(
  parameter int DW         = 8,
  parameter int HOLD_DEPTH = 2
);
  localparam int HC_W = $clog2(HOLD_DEPTH + 1);

  // source / FSM side
  logic            packet_valid;
  logic [DW-1:0]   data_in;
  logic            fifo_full;
  logic            detect_add;
  logic            lfd_state;
  logic            ld_state;
  logic            laf_state;
  logic            full_state;
  logic            rst_int_reg;

  // packet register outputs
  logic [DW-1:0]   dout;
  logic            dout_vld;
  logic            parity_done;
  logic            low_packet_valid;
  logic            err;
  logic            len_err;
  logic            hold_ovf;
  logic [HC_W-1:0] hold_count;

  modport master (
    output packet_valid, data_in, fifo_full,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  dout, dout_vld, parity_done, low_packet_valid,
    input  err, len_err, hold_ovf, hold_count
  );

  modport slave (
    input  packet_valid, data_in, fifo_full,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output dout, dout_vld, parity_done, low_packet_valid,
    output err, len_err, hold_ovf, hold_count
  );
endinterface

// File: rtl/router_pkt_reg.sv
// -----------------------------------------------------------------------------
// router_pkt_reg
// Packet register and parity/length checker between the router FSM and the
// per-port output FIFOs. Captures the header, forwards header, payload and
// parity bytes to dout, parks bytes that arrive while the FIFO is full in a
// small hold buffer, and checks running parity and payload length.
//
// Ports:
//   clk     : clock, all state updates on the rising edge
//   resetn  : asynchronous active-low reset
//   bus     : router_pkt_reg_if.slave
//             in : packet_valid, data_in, fifo_full, detect_add, lfd_state,
//                  ld_state, laf_state, full_state, rst_int_reg
//             out: dout, dout_vld, parity_done, low_packet_valid, err,
//                  len_err, hold_ovf, hold_count
// -----------------------------------------------------------------------------
module router_pkt_reg #(
  parameter int DW         = 8,
  parameter int ADDR_W     = 2,
  parameter int HOLD_DEPTH = 2,
  parameter int ODD_PARITY = 0
) (
  input  logic           clk,
  input  logic           resetn,
  router_pkt_reg_if.slave bus
);
  localparam int LEN_W = DW - ADDR_W;
  localparam int HC_W  = $clog2(HOLD_DEPTH + 1);

  localparam logic [LEN_W-1:0] LEN_MAX   = {LEN_W{1'b1}};
  localparam logic [HC_W-1:0]  HOLD_FULL = HC_W'(HOLD_DEPTH);
  // Odd parity compares against the inverted XOR.
  localparam logic [DW-1:0]    PAR_MASK  = (ODD_PARITY != 0) ? {DW{1'b1}} : {DW{1'b0}};

  logic [DW-1:0]    hdr_q, hdr_d;
  logic [DW-1:0]    parity_q, parity_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    pkt_par_q, pkt_par_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             parity_done_q, parity_done_d;
  logic             lpv_q, lpv_d;
  logic             err_q, err_d;
  logic             len_err_q, len_err_d;
  logic             hold_ovf_q, hold_ovf_d;
  logic [DW-1:0]    hold_mem_q [HOLD_DEPTH];
  logic [DW-1:0]    hold_mem_d [HOLD_DEPTH];
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;

  logic fwd;      // current ld_state byte must go to dout or the hold buffer
  logic lpv_set;  // parity byte seen this cycle

  always_comb begin
    hdr_d         = hdr_q;
    parity_d      = parity_q;
    cnt_d         = cnt_q;
    pkt_par_d     = pkt_par_q;
    dout_d        = dout_q;
    dout_vld_d    = 1'b0;
    parity_done_d = parity_done_q;
    lpv_d         = lpv_q;
    err_d         = err_q;
    len_err_d     = len_err_q;
    hold_ovf_d    = hold_ovf_q;
    hold_cnt_d    = hold_cnt_q;
    fwd           = 1'b0;
    lpv_set       = 1'b0;
    for (int i = 0; i < HOLD_DEPTH; i++) begin
      hold_mem_d[i] = hold_mem_q[i];
    end

    // Check completes once the parity byte is in and nothing is still parked.
    // Evaluated before the strobe chain so a new header clears it.
    if (lpv_q && (hold_cnt_q == '0) && !parity_done_q) begin
      parity_done_d = 1'b1;
      err_d         = ((parity_q ^ PAR_MASK) != pkt_par_q);
      len_err_d     = (cnt_q != hdr_q[DW-1:ADDR_W]);
    end

    // Strobes are mutually exclusive by priority; a push and a pop therefore
    // never happen in the same cycle.
    if (bus.detect_add) begin
      if (bus.packet_valid) begin
        hdr_d         = bus.data_in;
        parity_d      = '0;
        cnt_d         = '0;
        parity_done_d = 1'b0;
        err_d         = 1'b0;
        len_err_d     = 1'b0;
        hold_ovf_d    = 1'b0;
        lpv_d         = 1'b0;
      end
    end else if (bus.lfd_state) begin
      dout_d     = hdr_q;
      dout_vld_d = 1'b1;
      parity_d   = parity_q ^ hdr_q;
    end else if (bus.ld_state) begin
      if (bus.packet_valid && !bus.full_state) begin
        parity_d = parity_q ^ bus.data_in;
        if (cnt_q != LEN_MAX) begin
          cnt_d = cnt_q + LEN_W'(1);
        end
        fwd = 1'b1;
      end else if (!bus.packet_valid) begin
        // Parity byte: forwarded but neither XORed nor counted.
        pkt_par_d = bus.data_in;
        lpv_d     = 1'b1;
        lpv_set   = 1'b1;
        fwd       = 1'b1;
      end

      if (fwd) begin
        if (!bus.fifo_full && (hold_cnt_q == '0)) begin
          dout_d     = bus.data_in;
          dout_vld_d = 1'b1;
        end else if (hold_cnt_q != HOLD_FULL) begin
          for (int i = 0; i < HOLD_DEPTH; i++) begin
            if (i == int'(hold_cnt_q)) begin
              hold_mem_d[i] = bus.data_in;
            end
          end
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end else begin
          hold_ovf_d = 1'b1;
        end
      end
    end else if (bus.laf_state) begin
      if (!bus.fifo_full && (hold_cnt_q != '0)) begin
        dout_d     = hold_mem_q[0];
        dout_vld_d = 1'b1;
        // Head is always entry 0; shift the rest down to keep arrival order.
        for (int i = 0; i < HOLD_DEPTH - 1; i++) begin
          hold_mem_d[i] = hold_mem_q[i+1];
        end
        hold_cnt_d = hold_cnt_q - HC_W'(1);
      end
    end

    // Internal reset flushes the hold buffer; a parity byte arriving in the
    // same cycle keeps low_packet_valid set.
    if (bus.rst_int_reg) begin
      hold_cnt_d = '0;
      if (!lpv_set) begin
        lpv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hdr_q         <= '0;
      parity_q      <= '0;
      cnt_q         <= '0;
      pkt_par_q     <= '0;
      dout_q        <= '0;
      dout_vld_q    <= 1'b0;
      parity_done_q <= 1'b0;
      lpv_q         <= 1'b0;
      err_q         <= 1'b0;
      len_err_q     <= 1'b0;
      hold_ovf_q    <= 1'b0;
      hold_cnt_q    <= '0;
      for (int i = 0; i < HOLD_DEPTH; i++) begin
        hold_mem_q[i] <= '0;
      end
    end else begin
      hdr_q         <= hdr_d;
      parity_q      <= parity_d;
      cnt_q         <= cnt_d;
      pkt_par_q     <= pkt_par_d;
      dout_q        <= dout_d;
      dout_vld_q    <= dout_vld_d;
      parity_done_q <= parity_done_d;
      lpv_q         <= lpv_d;
      err_q         <= err_d;
      len_err_q     <= len_err_d;
      hold_ovf_q    <= hold_ovf_d;
      hold_cnt_q    <= hold_cnt_d;
      for (int i = 0; i < HOLD_DEPTH; i++) begin
        hold_mem_q[i] <= hold_mem_d[i];
      end
    end
  end

  assign bus.dout             = dout_q;
  assign bus.dout_vld         = dout_vld_q;
  assign bus.parity_done      = parity_done_q;
  assign bus.low_packet_valid = lpv_q;
  assign bus.err              = err_q;
  assign bus.len_err          = len_err_q;
  assign bus.hold_ovf         = hold_ovf_q;
  assign bus.hold_count       = hold_cnt_q;
endmodule

// File: tb/tb_router_pkt_reg.sv
// -----------------------------------------------------------------------------
// tb_router_pkt_reg
// Directed bench for router_pkt_reg (DW=8, ADDR_W=2, HOLD_DEPTH=2, even
// parity). Each scenario task drives strobes and checks outputs inline.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_router_pkt_reg;
  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_fail;

  router_pkt_reg_if #(.DW(8), .HOLD_DEPTH(2)) bif ();

  router_pkt_reg #(
    .DW(8), .ADDR_W(2), .HOLD_DEPTH(2), .ODD_PARITY(0)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus, then wait past the edge that consumes it.
  task automatic drive(input logic da, input logic lfd, input logic ld,
                       input logic laf, input logic pv, input logic ff,
                       input logic [7:0] d);
    bif.detect_add   = da;
    bif.lfd_state    = lfd;
    bif.ld_state     = ld;
    bif.laf_state    = laf;
    bif.packet_valid = pv;
    bif.fifo_full    = ff;
    bif.data_in      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({bif.dout, bif.dout_vld, bif.parity_done, bif.low_packet_valid,
         bif.err, bif.len_err, bif.hold_ovf, bif.hold_count} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dout=%h vld=%b pd=%b lpv=%b err=%b lerr=%b ovf=%b hc=%0d required all 0",
               bif.dout, bif.dout_vld, bif.parity_done, bif.low_packet_valid,
               bif.err, bif.len_err, bif.hold_ovf, bif.hold_count);
    end
    $display("test_reset: outputs dout=%h vld=%b hc=%0d", bif.dout, bif.dout_vld, bif.hold_count);
  endtask

  task automatic test_clean_packet;
    logic [7:0] pay [3];
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    drive(1, 0, 0, 0, 1, 0, 8'h0D);
    drive(0, 1, 0, 0, 0, 0, 8'h00);
    n_cmp++;
    if ({bif.dout_vld, bif.dout} !== 9'h10D) begin
      n_fail++;
      $display("FAIL clean_hdr: got vld=%b dout=%h required vld=1 dout=0d", bif.dout_vld, bif.dout);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 1, 0, pay[i]);
      n_cmp++;
      if ({bif.dout_vld, bif.dout} !== {1'b1, pay[i]}) begin
        n_fail++;
        $display("FAIL clean_payload%0d: got vld=%b dout=%h required vld=1 dout=%h", i, bif.dout_vld, bif.dout, pay[i]);
      end
    end
    drive(0, 0, 1, 0, 0, 0, 8'h0D);
    n_cmp++;
    if ({bif.dout_vld, bif.dout, bif.low_packet_valid, bif.parity_done} !== {1'b1, 8'h0D, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL clean_parity_byte: got vld=%b dout=%h lpv=%b pd=%b required 1/0d/1/0",
               bif.dout_vld, bif.dout, bif.low_packet_valid, bif.parity_done);
    end
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    n_cmp++;
    if ({bif.dout_vld, bif.parity_done, bif.err, bif.len_err} !== 4'b0100) begin
      n_fail++;
      $display("FAIL clean_done: got vld=%b pd=%b err=%b lerr=%b required 0/1/0/0",
               bif.dout_vld, bif.parity_done, bif.err, bif.len_err);
    end
    $display("test_clean_packet: pd=%b err=%b len_err=%b", bif.parity_done, bif.err, bif.len_err);
  endtask

  task automatic test_parity_error;
    logic [7:0] pay [3];
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    drive(1, 0, 0, 0, 1, 0, 8'h0D);
    drive(0, 1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 1, 0, pay[i]);
    drive(0, 0, 1, 0, 0, 0, 8'h0C);
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    n_cmp++;
    if ({bif.parity_done, bif.err, bif.len_err} !== 3'b110) begin
      n_fail++;
      $display("FAIL parity_err_set: got pd=%b err=%b lerr=%b required 1/1/0", bif.parity_done, bif.err, bif.len_err);
    end
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    n_cmp++;
    if ({bif.parity_done, bif.err} !== 2'b11) begin
      n_fail++;
      $display("FAIL parity_err_hold: got pd=%b err=%b required 1/1", bif.parity_done, bif.err);
    end
    drive(1, 0, 0, 0, 1, 0, 8'h0D);
    n_cmp++;
    if ({bif.parity_done, bif.err, bif.len_err, bif.low_packet_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL parity_err_clear: got pd=%b err=%b lerr=%b lpv=%b required 0/0/0/0",
               bif.parity_done, bif.err, bif.len_err, bif.low_packet_valid);
    end
    $display("test_parity_error: err cleared to %b by detect_add", bif.err);
  endtask

  task automatic test_len_error;
    logic [7:0] pay [3];
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    // header 0x11: len 4, addr 1; parity 0x11^0x11^0x22^0x33 = 0x11
    drive(1, 0, 0, 0, 1, 0, 8'h11);
    drive(0, 1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 1, 0, pay[i]);
    drive(0, 0, 1, 0, 0, 0, 8'h11);
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    n_cmp++;
    if ({bif.parity_done, bif.err, bif.len_err} !== 3'b101) begin
      n_fail++;
      $display("FAIL len_err: got pd=%b err=%b lerr=%b required 1/0/1", bif.parity_done, bif.err, bif.len_err);
    end
    $display("test_len_error: len_err=%b err=%b", bif.len_err, bif.err);
  endtask

  task automatic test_hold_drain;
    drive(1, 0, 0, 0, 1, 0, 8'h0D);
    drive(0, 1, 0, 0, 0, 0, 8'h00);
    drive(0, 0, 1, 0, 1, 0, 8'h11);
    drive(0, 0, 1, 0, 1, 1, 8'h22);
    n_cmp++;
    if ({bif.dout_vld, bif.hold_count} !== 3'b0_01) begin
      n_fail++;
      $display("FAIL hold_push1: got vld=%b hc=%0d required vld=0 hc=1", bif.dout_vld, bif.hold_count);
    end
    drive(0, 0, 1, 0, 1, 1, 8'h33);
    n_cmp++;
    if ({bif.dout_vld, bif.hold_count, bif.hold_ovf} !== 4'b0_10_0) begin
      n_fail++;
      $display("FAIL hold_push2: got vld=%b hc=%0d ovf=%b required vld=0 hc=2 ovf=0", bif.dout_vld, bif.hold_count, bif.hold_ovf);
    end
    // FIFO still full during laf: nothing leaves
    drive(0, 0, 0, 1, 0, 1, 8'h00);
    n_cmp++;
    if ({bif.dout_vld, bif.hold_count} !== 3'b0_10) begin
      n_fail++;
      $display("FAIL hold_stall: got vld=%b hc=%0d required vld=0 hc=2", bif.dout_vld, bif.hold_count);
    end
    drive(0, 0, 0, 1, 0, 0, 8'h00);
    n_cmp++;
    if ({bif.dout_vld, bif.dout, bif.hold_count} !== {1'b1, 8'h22, 2'd1}) begin
      n_fail++;
      $display("FAIL hold_pop1: got vld=%b dout=%h hc=%0d required 1/22/1", bif.dout_vld, bif.dout, bif.hold_count);
    end
    drive(0, 0, 0, 1, 0, 0, 8'h00);
    n_cmp++;
    if ({bif.dout_vld, bif.dout, bif.hold_count} !== {1'b1, 8'h33, 2'd0}) begin
      n_fail++;
      $display("FAIL hold_pop2: got vld=%b dout=%h hc=%0d required 1/33/0", bif.dout_vld, bif.dout, bif.hold_count);
    end
    drive(0, 0, 1, 0, 0, 0, 8'h0D);
    n_cmp++;
    if ({bif.dout_vld, bif.dout} !== 9'h10D) begin
      n_fail++;
      $display("FAIL hold_parity_byte: got vld=%b dout=%h required 1/0d", bif.dout_vld, bif.dout);
    end
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    n_cmp++;
    if ({bif.parity_done, bif.err, bif.len_err, bif.hold_ovf} !== 4'b1000) begin
      n_fail++;
      $display("FAIL hold_done: got pd=%b err=%b lerr=%b ovf=%b required 1/0/0/0",
               bif.parity_done, bif.err, bif.len_err, bif.hold_ovf);
    end
    $display("test_hold_drain: hc=%0d pd=%b", bif.hold_count, bif.parity_done);
  endtask

  task automatic test_hold_overflow;
    drive(1, 0, 0, 0, 1, 0, 8'h0D);
    drive(0, 1, 0, 0, 0, 0, 8'h00);
    drive(0, 0, 1, 0, 1, 1, 8'h11);
    drive(0, 0, 1, 0, 1, 1, 8'h22);
    n_cmp++;
    if (bif.hold_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_early: got ovf=%b required 0", bif.hold_ovf);
    end
    drive(0, 0, 1, 0, 1, 1, 8'h33);
    n_cmp++;
    if ({bif.hold_ovf, bif.hold_count} !== 3'b1_10) begin
      n_fail++;
      $display("FAIL ovf_set: got ovf=%b hc=%0d required ovf=1 hc=2", bif.hold_ovf, bif.hold_count);
    end
    drive(0, 0, 0, 1, 0, 0, 8'h00);
    drive(0, 0, 0, 1, 0, 0, 8'h00);
    n_cmp++;
    if ({bif.dout, bif.hold_count, bif.hold_ovf} !== {8'h22, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_drain: got dout=%h hc=%0d ovf=%b required 22/0/1", bif.dout, bif.hold_count, bif.hold_ovf);
    end
    // dropped byte was still XORed and counted, so the check stays clean
    drive(0, 0, 1, 0, 0, 0, 8'h0D);
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    n_cmp++;
    if ({bif.parity_done, bif.err, bif.len_err} !== 3'b100) begin
      n_fail++;
      $display("FAIL ovf_check: got pd=%b err=%b lerr=%b required 1/0/0", bif.parity_done, bif.err, bif.len_err);
    end
    $display("test_hold_overflow: ovf=%b hc=%0d", bif.hold_ovf, bif.hold_count);
  endtask

  task automatic test_async_reset;
    drive(1, 0, 0, 0, 1, 0, 8'h0D);
    drive(0, 1, 0, 0, 0, 0, 8'h00);
    drive(0, 0, 1, 0, 1, 1, 8'h11);
    drive(0, 0, 1, 0, 1, 0, 8'h22);
    // hold buffer non-empty, dout holds the header
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({bif.dout, bif.dout_vld, bif.low_packet_valid, bif.hold_count, bif.hold_ovf} !== 13'h0) begin
      n_fail++;
      $display("FAIL async_reset: got dout=%h vld=%b lpv=%b hc=%0d ovf=%b required all 0",
               bif.dout, bif.dout_vld, bif.low_packet_valid, bif.hold_count, bif.hold_ovf);
    end
    #1 resetn = 1'b1;
    $display("test_async_reset: dout=%h hc=%0d after reset", bif.dout, bif.hold_count);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    resetn = 1'b0;
    bif.packet_valid = 1'b0;
    bif.data_in      = 8'h00;
    bif.fifo_full    = 1'b0;
    bif.detect_add   = 1'b0;
    bif.lfd_state    = 1'b0;
    bif.ld_state     = 1'b0;
    bif.laf_state    = 1'b0;
    bif.full_state   = 1'b0;
    bif.rst_int_reg  = 1'b0;
    #1;
    test_reset();
    @(posedge clk);
    #1 resetn = 1'b1;
    test_clean_packet();
    test_parity_error();
    test_len_error();
    test_hold_drain();
    test_hold_overflow();
    test_async_reset();
    test_clean_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/router_pkt_reg.md
# router_pkt_reg

Parametrised packet register and parity/length checker for the router datapath, sitting between the router FSM and the per-port output FIFOs. It captures the header, forwards header, payload and parity bytes to `dout`, and absorbs bytes arriving while the FIFO is full in a HOLD_DEPTH-entry hold buffer. It computes running parity and payload length, and flags parity errors, length errors and hold-buffer overflow.

## Interface
- `DW`, 8: data width; header = {length[DW-1:ADDR_W], addr[ADDR_W-1:0]}
- `ADDR_W`, 2: address field width; LEN_W = DW-ADDR_W
- `HOLD_DEPTH`, 2: hold-buffer entries (≥1)
- `ODD_PARITY`, 0: 0 = packet parity byte equals XOR of header+payload; 1 = equals its bitwise inverse
- `clk` in 1: clock, all state on rising edge
- `resetn` in 1: reset, asynchronous, active-low
- `packet_valid` in 1: source byte valid; low during ld_state marks the parity byte
- `data_in` in DW: source byte
- `fifo_full` in 1: selected output FIFO full
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg` in 1 each: FSM state/control strobes
- `dout` out DW: byte to FIFO
- `dout_vld` out 1: `dout` loaded this cycle (FIFO write qualifier)
- `parity_done` out 1: packet fully forwarded, check complete
- `low_packet_valid` out 1: parity byte received
- `err` out 1: parity mismatch
- `len_err` out 1: payload count ≠ header length
- `hold_ovf` out 1: sticky, byte dropped on full hold buffer
- `hold_count` out $clog2(HOLD_DEPTH+1): bytes in hold buffer

## Operation
- Reset (async, resetn=0): all outputs, hold buffer, header, internal parity, byte count and packet parity are 0.
- Priority when several strobes are high in one cycle: detect_add > lfd_state > ld_state > laf_state.
- detect_add && packet_valid: hdr ← data_in; clear internal parity, byte count, parity_done, err, len_err, hold_ovf, low_packet_valid.
- lfd_state: dout ← hdr, dout_vld=1; parity ^= hdr.
- ld_state && packet_valid && !full_state: payload byte; parity ^= data_in; byte count +1, saturating at 2^LEN_W−1.
- ld_state && !packet_valid: parity byte; pkt_parity ← data_in; low_packet_valid ← 1; not XORed into parity, not counted.
- Forwarding of ld_state bytes: if !fifo_full && hold buffer empty, dout ← data_in, dout_vld=1. Otherwise push to hold buffer tail. If the buffer is full, drop the byte and set hold_ovf (parity/count still updated).
- laf_state && !fifo_full && hold_count>0: dout ← head, pop, dout_vld=1. Bytes leave in arrival order.
- parity_done set when low_packet_valid && hold_count==0 && !parity_done. On that same edge, err ← (parity ^ (ODD_PARITY ? all-ones : 0)) ≠ pkt_parity, and len_err ← byte count ≠ hdr[DW-1:ADDR_W]. err, len_err and parity_done hold until the next detect_add.
- rst_int_reg: clears low_packet_valid and flushes the hold buffer. A simultaneous low_packet_valid set wins over the clear.

## Timing
- All outputs are registered; dout/dout_vld update one edge after the qualifying strobe.
- Header: detect_add cycle N, lfd_state N+1 → dout=header after edge N+1.
- Payload with fifo_full=0: byte on data_in at edge k appears on dout after edge k.
- parity_done: earliest one cycle after low_packet_valid rises (hold empty), same edge as err/len_err.
- Hold buffer: a push and a pop never occur in the same cycle, because ld_state and laf_state are exclusive by priority. hold_count is exact after every edge.
- resetn deassertion mid-packet: block idles until the next detect_add. Bytes before that are ignored except ld_state/laf_state rules operating on cleared state.

## Test plan
- Clean packet, DW=8: header 0x0D (len 3, addr 1), payload 0x11/0x22/0x33, parity 0x0D → dout sequence 0x0D,0x11,0x22,0x33,0x0D with dout_vld each; parity_done=1, err=0, len_err=0.
- Same packet with parity 0x0C → err=1 on the parity_done edge; err clears on next detect_add.
- Header 0x11 (len 4) with 3 payload bytes and correct XOR parity → len_err=1, err=0.
- fifo_full=1 during payload bytes 0x22,0x33 (HOLD_DEPTH=2) → hold_count=2. laf_state with fifo_full=0 drains 0x22 then 0x33, hold_count=0, then parity_done.
- fifo_full held for 3 payload bytes, HOLD_DEPTH=2 → third byte dropped, hold_ovf=1, hold_count=2.
- resetn pulsed low mid-payload (async, between edges) → all outputs 0 immediately. Next full packet checks correctly.
